// File: rtl/scs8hd_descrm_par_8.sv
// scs8hd_descrm_par_8: serial receive path for the test links.
// Undoes the x^7 + x^4 + 1 self-synchronizing scrambler, deserializes the
// descrambled stream into WIDTH-bit words plus one even-parity bit, and
// reports the parity check alongside each completed word.
module scs8hd_descrm_par_8 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             D,
  input  logic             DV,
  input  logic             SOF,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic             PERR,
  output logic             LOCK
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    PAR
  } state_t;

  state_t           state;
  logic [6:0]       s;
  logic [2:0]       cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] data;
  logic             word_ok;
  logic             b;

  // Descrambled bit: the raw line bit XOR the two tapped history bits.
  always_comb begin
    b = D ^ s[6] ^ s[3];
  end

  // Descrambler history, lock counter, word framing and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= HUNT;
      s       <= '0;
      cnt     <= '0;
      idx     <= '0;
      data    <= '0;
      word_ok <= 1'b0;
      Q       <= '0;
      QV      <= 1'b0;
      PERR    <= 1'b0;
      LOCK    <= 1'b0;
    end else begin
      QV <= 1'b0;
      if (DV) begin
        // History takes the scrambled bit, not the descrambled one.
        s <= {s[5:0], D};
        if (cnt != 3'd7) cnt <= cnt + 3'd1;
        if (cnt == 3'd6) LOCK <= 1'b1;

        if (SOF) begin
          // SOF overrides any framing in progress; a partial word is dropped.
          data[0] <= b;
          idx     <= IW'(1);
          state   <= DATA;
          word_ok <= LOCK;
        end else begin
          case (state)
            HUNT: ;
            DATA: begin
              data[idx] <= b;
              if (idx == '0) word_ok <= LOCK;
              idx <= idx + IW'(1);
              if (idx == IDX_LAST) state <= PAR;
            end
            PAR: begin
              if (word_ok) begin
                Q    <= data;
                PERR <= ^{data, b};
                QV   <= 1'b1;
              end
              idx   <= '0;
              state <= DATA;
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_scs8hd_descrm_par_8.sv
// Directed bench for scs8hd_descrm_par_8: a reset-aligned scrambler drives
// the line, and word results are checked against hand-derived constants.
module tb_scs8hd_descrm_par_8;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       D;
  logic       DV;
  logic       SOF;
  logic [7:0] Q;
  logic       QV;
  logic       PERR;
  logic       LOCK;

  int total = 0;
  int bad = 0;
  int qv_seen = 0;
  int qv_mark;
  logic [6:0] tx = '0;

  scs8hd_descrm_par_8 #(.WIDTH(8)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .D    (D),
    .DV   (DV),
    .SOF  (SOF),
    .Q    (Q),
    .QV   (QV),
    .PERR (PERR),
    .LOCK (LOCK)
  );

  always #5 CLK = ~CLK;

  // QV pulses observed mid-cycle.
  always @(negedge CLK) if (QV === 1'b1) qv_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scramble one bit and present it for exactly one clock edge.
  task automatic send_bit(input logic bit_in, input logic sof_in);
    logic c;
    c   = bit_in ^ tx[6] ^ tx[3];
    D   = c;
    DV  = 1'b1;
    SOF = sof_in;
    @(posedge CLK);
    #1;
    tx  = {tx[5:0], c};
    DV  = 1'b0;
    SOF = 1'b0;
    D   = 1'b0;
  endtask

  task automatic idle(input int n);
    DV = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Send 8 data bits LSB first, optional gap, then parity; check QV framing.
  task automatic send_word(input string tag, input logic [7:0] w, input logic p,
                           input logic sof_first, input int gap_at, input int gap_len,
                           input logic exp_qv, input logic [7:0] exp_q,
                           input logic exp_perr);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], sof_first && (i == 0));
      if (i == gap_at) begin
        idle(gap_len);
        chk({tag, "_qv_gap"}, 32'(QV), 32'd0);
      end
    end
    chk({tag, "_qv_pre"}, 32'(QV), 32'd0);
    send_bit(p, 1'b0);
    chk({tag, "_qv"}, 32'(QV), 32'(exp_qv));
    chk({tag, "_q"}, 32'(Q), 32'(exp_q));
    chk({tag, "_perr"}, 32'(PERR), 32'(exp_perr));
  endtask

  task automatic pulse_reset();
    #2;
    RESET = 1'b1;
    #1;
    chk("rst_q", 32'(Q), 32'h00);
    chk("rst_qv", 32'(QV), 32'd0);
    chk("rst_perr", 32'(PERR), 32'd0);
    chk("rst_lock", 32'(LOCK), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    tx    = '0;
  endtask

  initial begin
    RESET = 1'b1;
    D     = 1'b0;
    DV    = 1'b0;
    SOF   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("init_q", 32'(Q), 32'h00);
    chk("init_qv", 32'(QV), 32'd0);
    chk("init_perr", 32'(PERR), 32'd0);
    chk("init_lock", 32'(LOCK), 32'd0);
    RESET = 1'b0;
    idle(2);
    chk("idle_lock", 32'(LOCK), 32'd0);

    // Lock-up: seven zero bits, LOCK follows the seventh.
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
    chk("lock_6", 32'(LOCK), 32'd0);
    send_bit(1'b0, 1'b0);
    chk("lock_7", 32'(LOCK), 32'd1);
    send_word("a5", 8'hA5, 1'b0, 1'b1, -1, 0, 1'b1, 8'hA5, 1'b0);

    // Parity error then a clean word, back-to-back without SOF.
    send_word("3c", 8'h3C, 1'b1, 1'b0, -1, 0, 1'b1, 8'h3C, 1'b1);
    send_word("01", 8'h01, 1'b1, 1'b0, -1, 0, 1'b1, 8'h01, 1'b0);
    idle(3);
    chk("hold_qv", 32'(QV), 32'd0);
    chk("hold_q", 32'(Q), 32'h01);
    chk("hold_perr", 32'(PERR), 32'd0);

    // Three words, SOF on the first only, two idle cycles inside the second.
    qv_mark = qv_seen;
    send_word("w00", 8'h00, 1'b0, 1'b1, -1, 0, 1'b1, 8'h00, 1'b0);
    send_word("wff", 8'hFF, 1'b0, 1'b0, 3, 2, 1'b1, 8'hFF, 1'b0);
    send_word("w5a", 8'h5A, 1'b0, 1'b0, -1, 0, 1'b1, 8'h5A, 1'b0);
    idle(1);
    chk("b2b_count", 32'(qv_seen - qv_mark), 32'd3);

    // Resync: SOF at idx 4 drops the partial word.
    qv_mark = qv_seen;
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    send_word("w81", 8'h81, 1'b0, 1'b1, -1, 0, 1'b1, 8'h81, 1'b0);
    idle(1);
    chk("resync_count", 32'(qv_seen - qv_mark), 32'd1);

    // Mid-word reset with Q holding 0x81.
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    pulse_reset();
    idle(2);
    chk("post_rst_lock", 32'(LOCK), 32'd0);

    // Pre-lock word: SOF on the 3rd bit after reset is silent.
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_word("pre42", 8'h42, 1'b0, 1'b1, -1, 0, 1'b0, 8'h00, 1'b0);
    chk("pre_lock", 32'(LOCK), 32'd1);
    send_word("w24", 8'h24, 1'b0, 1'b0, -1, 0, 1'b1, 8'h24, 1'b0);

    // SOF on the 7th bit: pre-increment LOCK is 0, so that word is silent.
    pulse_reset();
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
    send_word("sof7", 8'h99, 1'b1, 1'b1, -1, 0, 1'b0, 8'h00, 1'b0);
    send_word("w66", 8'h66, 1'b1, 1'b0, -1, 0, 1'b1, 8'h66, 1'b1);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
